// File: rtl/fp_pkg.sv
// Shared classes, flag indices and width helpers for the pipelined FP multiplier.
package fp_pkg;

   typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;

   function automatic int fp_width(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int fp_prod_w(input int man_w);
      return 2 * man_w + 2;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Stage-3 combinational logic: normalise, round-to-nearest-even, range check,
// special-case selection and exception flags.
module fp_round_pack import fp_pkg::*; #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = fp_width(EXP_W, MAN_W),
   localparam int PW    = fp_prod_w(MAN_W)
) (
   input  logic             sign,
   input  fp_class_e        cls_a,
   input  fp_class_e        cls_b,
   input  logic [EXP_W+1:0] esum,
   input  logic [PW-1:0]    prod,
   output logic [W-1:0]     res,
   output logic [3:0]       flags
);

   localparam logic [EXP_W+1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

   logic [PW-2:0]    norm;
   logic [MAN_W-1:0] frac;
   logic             guard;
   logic             sticky;
   logic             rnd_up;
   logic [MAN_W:0]   frac_rnd;
   logic [EXP_W+1:0] exp_fin;
   logic             any_nan;
   logic             any_inf;
   logic             any_zero;
   logic             ovf;
   logic             unf;

   always_comb begin
      res      = '0;
      flags    = '0;
      // Leading one ends up just above norm's top bit in both product ranges
      norm     = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
      frac     = norm[PW-2 -: MAN_W];
      guard    = norm[MAN_W];
      sticky   = |norm[MAN_W-1:0];
      rnd_up   = guard & (sticky | frac[0]);
      frac_rnd = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
      exp_fin  = esum + {{(EXP_W+1){1'b0}}, prod[PW-1]}
                      + {{(EXP_W+1){1'b0}}, frac_rnd[MAN_W]};
      ovf      = !exp_fin[EXP_W+1] && (exp_fin >= EXP_MAX);
      unf      = exp_fin[EXP_W+1] || (exp_fin == '0);
      any_nan  = (cls_a == FP_NAN)  || (cls_b == FP_NAN);
      any_inf  = (cls_a == FP_INF)  || (cls_b == FP_INF);
      any_zero = (cls_a == FP_ZERO) || (cls_b == FP_ZERO);

      if (any_nan || (any_inf && any_zero)) begin
         res            = {sign, {(EXP_W+MAN_W){1'b1}}};
         flags[FLG_INV] = 1'b1;
      end else if (any_inf) begin
         res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (any_zero) begin
         res = {sign, {(W-1){1'b0}}};
      end else if (ovf) begin
         res            = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags[FLG_OVF] = 1'b1;
         flags[FLG_INX] = 1'b1;
      end else if (unf) begin
         res            = {sign, {(W-1){1'b0}}};
         flags[FLG_UNF] = 1'b1;
         flags[FLG_INX] = 1'b1;
      end else begin
         res            = {sign, exp_fin[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
         flags[FLG_INX] = guard | sticky;
      end
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE754 multiplier with valid/ready handshake and
// a single global advance enable.
module fp_mul_pipe import fp_pkg::*; #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = fp_width(EXP_W, MAN_W)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] op1,
   input  logic [W-1:0] op2,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] res,
   output logic [3:0]   flags
);

   localparam int               PW   = fp_prod_w(MAN_W);
   localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'(fp_bias(EXP_W));

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] f);
      if (e == '0) return FP_ZERO;
      if (e == '1) return (f == '0) ? FP_INF : FP_NAN;
      return FP_NORM;
   endfunction

   logic             en;
   logic             v1;
   logic             v2;
   logic             s1_sign;
   fp_class_e        s1_ca;
   fp_class_e        s1_cb;
   logic [EXP_W+1:0] s1_esum;
   logic [MAN_W:0]   s1_ma;
   logic [MAN_W:0]   s1_mb;
   logic             s2_sign;
   fp_class_e        s2_ca;
   fp_class_e        s2_cb;
   logic [EXP_W+1:0] s2_esum;
   logic [PW-1:0]    s2_prod;
   logic [W-1:0]     rp_res;
   logic [3:0]       rp_flags;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         res       <= '0;
         flags     <= '0;
      end else if (en) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         res       <= rp_res;
         flags     <= rp_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (en && in_valid) begin
         s1_sign <= op1[W-1] ^ op2[W-1];
         s1_ca   <= classify(op1[W-2 -: EXP_W], op1[MAN_W-1:0]);
         s1_cb   <= classify(op2[W-2 -: EXP_W], op2[MAN_W-1:0]);
         s1_esum <= {2'b00, op1[W-2 -: EXP_W]} + {2'b00, op2[W-2 -: EXP_W]} - BIAS;
         s1_ma   <= {1'b1, op1[MAN_W-1:0]};
         s1_mb   <= {1'b1, op2[MAN_W-1:0]};
      end
      if (en) begin
         s2_sign <= s1_sign;
         s2_ca   <= s1_ca;
         s2_cb   <= s1_cb;
         s2_esum <= s1_esum;
         s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      end
   end

   fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
      .sign  (s2_sign),
      .cls_a (s2_ca),
      .cls_b (s2_cb),
      .esum  (s2_esum),
      .prod  (s2_prod),
      .res   (rp_res),
      .flags (rp_flags)
   );

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed vectors, binary16 instance,
// randomized streams with backpressure against an arithmetic reference model.
module tb_fp_mul_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] res;
   logic [3:0]  flags;

   logic [15:0] h_op1 = '0;
   logic [15:0] h_op2 = '0;
   logic        h_in_ready;
   logic        h_out_valid;
   logic [15:0] h_res;
   logic [3:0]  h_flags;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .flags(flags)
   );

   fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(h_in_ready),
      .op1(h_op1), .op2(h_op2), .out_valid(h_out_valid), .out_ready(out_ready),
      .res(h_res), .flags(h_flags)
   );

   // Reference: real-valued product of significands, rounded by integer
   // remainder comparison against one half ulp.
   function automatic void ref_mul(input int ew, input int mw,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [3:0] f);
      longint one, emax, bias, mmask, ua, ub, sa, sb, s, ea, eb, fa, fb;
      longint p, e, q, rem, half, rv;
      int sh;
      bit za, zb, ia, ib, na, nb;
      one = 1; ua = a; ub = b;
      emax = (one << ew) - 1; bias = (one << (ew - 1)) - 1; mmask = (one << mw) - 1;
      sa = (ua >> (ew + mw)) & 1; sb = (ub >> (ew + mw)) & 1; s = sa ^ sb;
      ea = (ua >> mw) & emax; eb = (ub >> mw) & emax;
      fa = ua & mmask; fb = ub & mmask;
      za = (ea == 0); zb = (eb == 0);
      ia = (ea == emax) && (fa == 0); ib = (eb == emax) && (fb == 0);
      na = (ea == emax) && (fa != 0); nb = (eb == emax) && (fb != 0);
      f = 4'd0;
      if (na || nb || (ia && zb) || (za && ib)) begin
         rv = (s << (ew + mw)) | ((one << (ew + mw)) - 1); f = 4'b1000;
      end else if (ia || ib) begin
         rv = (s << (ew + mw)) | (emax << mw);
      end else if (za || zb) begin
         rv = s << (ew + mw);
      end else begin
         p = ((one << mw) | fa) * ((one << mw) | fb);
         e = ea + eb - bias;
         if (p >= (one << (2 * mw + 1))) begin sh = mw + 1; e = e + 1; end
         else sh = mw;
         q = p >> sh; rem = p - (q << sh); half = one << (sh - 1);
         if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
         if (q == (one << (mw + 1))) begin q = q >> 1; e = e + 1; end
         if (e >= emax) begin
            rv = (s << (ew + mw)) | (emax << mw); f = 4'b0101 | 4'b0010 << 1 & 4'b0100;
            f = 4'b0101;
         end else if (e <= 0) begin
            rv = s << (ew + mw); f = 4'b0011;
         end else begin
            rv = (s << (ew + mw)) | (e << mw) | (q - (one << mw));
            f = (rem != 0) ? 4'b0001 : 4'b0000;
         end
      end
      r = 32'(rv);
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      int k;
      r = $urandom;
      k = $urandom_range(0, 15);
      if (k == 0) r[30:23] = 8'h00;
      else if (k == 1) begin
         r[30:23] = 8'hFF;
         if ($urandom_range(0, 1) == 1) r[22:0] = '0;
      end else if (k < 5) r[30:23] = 8'($urandom_range(1, 254));
      else r[30:23] = 8'($urandom_range(100, 154));
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || h_out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid: got %b/%b expected 0", out_valid, h_out_valid);
      end
      checks++;
      if (res !== 32'h0 || flags !== 4'h0) begin
         failures++; $display("FAIL reset_res_flags: got %h/%h expected 0/0", res, flags);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_directed();
      logic [31:0] va[11] = '{32'h41820000, 32'h41B00000, 32'h4059999A, 32'h4291CCCD,
                              32'hFF800000, 32'h7F800000, 32'hFF800000, 32'h3FA00000,
                              32'h7F000000, 32'h00800000, 32'h7FC00000};
      logic [31:0] vb[11] = '{32'h41100000, 32'hC0A00000, 32'h4059999A, 32'h41100000,
                              32'h00000000, 32'h00000000, 32'h40000000, 32'h00000000,
                              32'h40000000, 32'h3F000000, 32'h3F800000};
      logic [31:0] vr[11] = '{32'h43124000, 32'hC2DC0000, 32'h4138F5C3, 32'h44240667,
                              32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFF800000, 32'h00000000,
                              32'h7F800000, 32'h00000000, 32'h7FFFFFFF};
      logic [3:0]  vf[11] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h8, 4'h8, 4'h0, 4'h0, 4'h5, 4'h3, 4'h8};
      int lat;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         in_valid = 1'b1; op1 = va[i]; op2 = vb[i]; out_ready = 1'b1;
         @(negedge clk);
         in_valid = 1'b0; op1 = $urandom; op2 = $urandom;
         #1;
         lat = 1;
         while (!out_valid && lat < 10) begin
            @(negedge clk); #1; lat++;
         end
         checks++;
         if (lat !== 3) begin
            failures++; $display("FAIL dir_latency[%0d]: got %0d expected 3", i, lat);
         end
         checks++;
         if (res !== vr[i]) begin
            failures++; $display("FAIL dir_res[%0d]: got %h expected %h", i, res, vr[i]);
         end
         checks++;
         if (flags !== vf[i]) begin
            failures++; $display("FAIL dir_flags[%0d]: got %b expected %b", i, flags, vf[i]);
         end
      end
   endtask

   task automatic test_fp16();
      logic [15:0] va[2] = '{16'h4000, 16'h7BFF};
      logic [15:0] vb[2] = '{16'h4200, 16'h4000};
      logic [15:0] vr[2] = '{16'h4600, 16'h7C00};
      logic [3:0]  vf[2] = '{4'h0, 4'h5};
      int lat;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_valid = 1'b1; h_op1 = va[i]; h_op2 = vb[i]; out_ready = 1'b1;
         #1;
         checks++;
         if (h_in_ready !== 1'b1) begin
            failures++; $display("FAIL h_in_ready[%0d]: got %b expected 1", i, h_in_ready);
         end
         @(negedge clk);
         in_valid = 1'b0; h_op1 = 16'($urandom); h_op2 = 16'($urandom);
         #1;
         lat = 1;
         while (!h_out_valid && lat < 10) begin
            @(negedge clk); #1; lat++;
         end
         checks++;
         if (h_out_valid !== 1'b1 || h_res !== vr[i]) begin
            failures++; $display("FAIL h_res[%0d]: got %h (valid %b) expected %h", i, h_res, h_out_valid, vr[i]);
         end
         checks++;
         if (h_flags !== vf[i]) begin
            failures++; $display("FAIL h_flags[%0d]: got %b expected %b", i, h_flags, vf[i]);
         end
      end
   endtask

   task automatic test_random_stream(input int n, input bit pattern_ready);
      logic [31:0] q_res[$];
      logic [3:0]  q_flg[$];
      logic [31:0] a, b, er, xr;
      logic [3:0]  ef, xf;
      bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int sent = 0, got = 0, cyc = 0;
      a = rand_op(); b = rand_op();
      while (got < n && cyc < 3000) begin
         @(negedge clk);
         if (pattern_ready) begin
            in_valid  = (sent < n);
            out_ready = pat[$urandom_range(0, 3)];
         end else begin
            in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
         end
         if (in_valid) begin op1 = a; op2 = b; end
         else begin op1 = $urandom; op2 = $urandom; end
         #1;
         checks++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            failures++; $display("FAIL stream_in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
         end
         if (in_valid && in_ready) begin
            ref_mul(8, 23, a, b, er, ef);
            q_res.push_back(er); q_flg.push_back(ef);
            sent++;
            a = rand_op(); b = rand_op();
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q_res.size() == 0) begin
               failures++; $display("FAIL stream_extra: got %h expected no result", res);
            end else begin
               xr = q_res.pop_front(); xf = q_flg.pop_front();
               if (res !== xr || flags !== xf) begin
                  failures++; $display("FAIL stream_res[%0d]: got %h/%b expected %h/%b", got, res, flags, xr, xf);
               end
            end
            got++;
         end
         cyc++;
      end
      checks++;
      if (got != n || q_res.size() != 0) begin
         failures++; $display("FAIL stream_count: got %0d results expected %0d (pending %0d)", got, n, q_res.size());
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_midstream();
      int cyc = 0;
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b0; op1 = rand_op(); op2 = rand_op();
      #1;
      while (!out_valid && cyc < 10) begin
         @(negedge clk); op1 = rand_op(); op2 = rand_op(); #1; cyc++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         failures++; $display("FAIL mid_fill: got out_valid %b expected 1", out_valid);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || res !== 32'h0 || flags !== 4'h0) begin
         failures++; $display("FAIL mid_reset: got %b/%h/%b expected 0/0/0", out_valid, res, flags);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset[%0d]: got %b/%b expected 0/1", i, out_valid, in_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_fp16();
      test_random_stream(60, 1'b0);
      test_random_stream(10, 1'b1);
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, fully pipelined IEEE754 multiplier; successor to double_multipler.
- Generic exponent/mantissa widths (binary32 default, binary16 supported) and a 3-stage pipeline accepting one operand pair per cycle.
- valid/ready handshake on both sides with backpressure; exception flags per result.
- Sits between the operand sequencer and the result writeback in the FP datapath.

Parameters:
- EXP_W, 8, exponent field width (≥4).
- MAN_W, 23, stored fraction width (≥4).
- Derived, not overridable: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the pair this cycle.
- op1  in  W  operand A.
- op2  in  W  operand B.
- out_valid  out  1  res/flags valid.
- out_ready  in  1  consumer accepts res this cycle.
- res  out  W  product.
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with res.

Behaviour:
- Reset (rst=0, async): all stage-valid bits 0, out_valid=0, res=0, flags=0. Data registers need no reset. in_ready=1 once reset is released.
- Global advance: en = !out_valid | out_ready; in_ready = en (combinational).
  - When en=0, every stage holds its contents.
  - Bubbles propagate as valid=0 and do not close gaps while stalled.
- Transfers:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - Latency: 3 cycles from input transfer to out_valid, with no stall.
  - Throughput: 1 result per cycle.
- Stage 1 (unpack/classify):
  - sign = s1 ^ s2.
  - Class per operand: ZERO (exp=0, includes subnormals, flushed to zero), INF (exp all-ones, frac=0), NAN (exp all-ones, frac≠0), NORM.
  - esum = e1 + e2 - BIAS, kept signed in EXP_W+2 bits.
  - Hidden 1 prepended to each fraction.
- Stage 2: (MAN_W+1)x(MAN_W+1) unsigned mantissa multiply into a 2·MAN_W+2 bit product; class and esum are carried along.
- Stage 3 (normalise/round/pack):
  - If product MSB=1: shift right 1 and increment esum.
  - Round-to-nearest-even using guard bit, plus sticky = OR of all lower bits.
  - A mantissa carry-out from rounding renormalises and increments the exponent.
  - inexact = guard | sticky.
- Special cases, in priority order:
  1. NAN in, or INF×ZERO: res = {sign, all-ones exp, all-ones frac}; invalid=1. Example: -inf×0 = 0xFFFFFFFF, +inf×0 = 0x7FFFFFFF.
  2. INF×(NORM|INF): res = {sign, all-ones, 0}; no flags.
  3. ZERO×(NORM|ZERO): res = {sign, 0, 0}; no flags.
  4. Final exp ≥ all-ones: res = signed inf; overflow=1, inexact=1.
  5. Final exp ≤ 0: res = signed zero (flush-to-zero); underflow=1, inexact=1.
- Simultaneous events:
  - Output accept and new input on the same cycle both occur; the pipe shifts.
  - out_ready low with in_valid high: in_ready=0, and no input is lost or duplicated.
- Reset mid-operation discards all in-flight results; no out_valid pulse follows reset release.
- op1/op2 are sampled only on an input transfer; their value at other times is ignored.

Decomposition:
- Package fp_pkg: class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}; flag bit indices FLG_INV=3, FLG_OVF=2, FLG_UNF=1, FLG_INX=0; width helper functions for W, BIAS and product width.
- One sub-module: fp_round_pack.
  - Combinational stage-3 logic: normalise, RNE, exponent range check, special-case mux, flags.
  - Parametrised by EXP_W/MAN_W.
  - Instantiated once; the stage-3 register stays in fp_mul_pipe.

Test Plan:
- 0x41820000 (16.25) × 0x41100000 (9.0) → res 0x43124000, flags 0. Then 0x41B00000 × 0xC0A00000 → 0xC2DC0000.
- 0x4059999A × 0x4059999A → 0x4138F5C3, inexact=1. Then 0x4291CCCD × 0x41100000 → 0x44240667 (RNE round-up).
- 0xFF800000 × 0x00000000 → 0xFFFFFFFF, invalid=1. 0xFF800000 × 0x40000000 → 0xFF800000, flags 0. 0x3FA00000 × 0 → 0x00000000.
- 0x7F000000 × 0x40000000 → 0x7F800000 with overflow+inexact. 0x00800000 × 0x3F000000 → 0x00000000 with underflow+inexact.
- Back-to-back stream of 10 pairs with out_ready toggling 1,0,0,1 pseudo-randomly:
  - results appear in order;
  - none is dropped or duplicated;
  - in_ready is 0 exactly when out_valid & !out_ready;
  - async reset asserted mid-stream clears out_valid immediately.
- EXP_W=5, MAN_W=10: 0x4000 × 0x4200 → 0x4600 (6.0). 0x7BFF × 0x4000 → 0x7C00 with overflow.
